basic_control_unit: RTL and testbench

- Hardwired control sequencer for the 16-bit basic computer: the other end of the datapath's control interface.
- Reads IR, AC, DR, IEN and R from the datapath and drives every bus select, ALU select, memory strobe and register reset/write/increment strobe on the same clock.
- Runs fetch, decode, indirect, execute and interrupt cycles with a 4-bit sequence counter (T0..T15).

---
 rtl/basic_control_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_basic_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_control_unit.sv
// Hardwired control sequencer for the 16-bit basic computer.
// Steps through fetch, decode, indirect, execute and interrupt cycles using a
// 4-bit sequence counter and drives every datapath strobe combinationally
// from that counter, the latched I flag and the datapath status inputs.
module basic_control_unit #(
   parameter logic [2:0] ALU_AND  = 3'd0,
   parameter logic [2:0] ALU_ADD  = 3'd1,
   parameter logic [2:0] ALU_LOAD = 3'd2,
   parameter logic [2:0] ALU_CMA  = 3'd3,
   parameter logic [2:0] ALU_CIR  = 3'd4,
   parameter logic [2:0] ALU_CIL  = 3'd5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        irq_req,
   input  logic [15:0] IR,
   input  logic [15:0] AC,
   input  logic [15:0] DR,
   input  logic        IEN,
   input  logic        R,
   output logic [2:0]  S,
   output logic [2:0]  alu_SEL,
   output logic        readMEM,
   output logic        writeMEM,
   output logic        resetAR,
   output logic        writeAR,
   output logic        incAR,
   output logic        resetPC,
   output logic        writePC,
   output logic        incPC,
   output logic        resetDR,
   output logic        writeDR,
   output logic        incDR,
   output logic        resetAC,
   output logic        writeAC,
   output logic        incAC,
   output logic        resetIR,
   output logic        writeIR,
   output logic        incIR,
   output logic        resetTR,
   output logic        writeTR,
   output logic        incTR,
   output logic        resetIEN,
   output logic        writeIEN,
   output logic        resetR,
   output logic        writeR,
   output logic [3:0]  SC,
   output logic        halted
);

   logic [3:0] sc_q, sc_d;
   logic       i_q, i_d;
   logic       run_q, run_d;
   logic       init_q;
   logic [2:0] opcode;
   logic       d7;

   assign opcode = IR[14:12];
   assign d7     = (opcode == 3'd7);
   assign SC     = sc_q;
   assign halted = ~run_q;
   assign incIR  = 1'b0;
   assign incTR  = 1'b0;

   // Sequencer state; reset abandons any instruction and re-enters the init cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sc_q   <= 4'd0;
         i_q    <= 1'b0;
         run_q  <= 1'b1;
         init_q <= 1'b1;
      end else begin
         sc_q   <= sc_d;
         i_q    <= i_d;
         run_q  <= run_d;
         init_q <= 1'b0;
      end
   end

   // Decode the current timing state into micro-operations and the next state.
   always_comb begin
      S        = 3'd0;
      alu_SEL  = ALU_AND;
      readMEM  = 1'b0;
      writeMEM = 1'b0;
      resetAR  = 1'b0;
      writeAR  = 1'b0;
      incAR    = 1'b0;
      resetPC  = 1'b0;
      writePC  = 1'b0;
      incPC    = 1'b0;
      resetDR  = 1'b0;
      writeDR  = 1'b0;
      incDR    = 1'b0;
      resetAC  = 1'b0;
      writeAC  = 1'b0;
      incAC    = 1'b0;
      resetIR  = 1'b0;
      writeIR  = 1'b0;
      resetTR  = 1'b0;
      writeTR  = 1'b0;
      resetIEN = 1'b0;
      writeIEN = 1'b0;
      resetR   = 1'b0;
      writeR   = 1'b0;
      sc_d     = sc_q;
      i_d      = i_q;
      run_d    = run_q;

      if (init_q) begin
         resetAR  = 1'b1;
         resetPC  = 1'b1;
         resetDR  = 1'b1;
         resetAC  = 1'b1;
         resetIR  = 1'b1;
         resetTR  = 1'b1;
         resetIEN = 1'b1;
         resetR   = 1'b1;
         sc_d     = 4'd0;
      end else if (!run_q) begin
         if (start) begin
            run_d = 1'b1;
            sc_d  = 4'd0;
         end
      end else begin
         sc_d = sc_q + 4'd1;
         if (sc_q >= 4'd3 && sc_q <= 4'd6 && !R && IEN && irq_req) begin
            writeR = 1'b1;
         end
         case (sc_q)
            4'd0: begin
               S = 3'd2;
               if (R) begin
                  resetAR = 1'b1;
                  writeTR = 1'b1;
               end else begin
                  writeAR = 1'b1;
               end
            end
            4'd1: begin
               if (R) begin
                  S        = 3'd6;
                  writeMEM = 1'b1;
                  resetPC  = 1'b1;
               end else begin
                  readMEM = 1'b1;
                  S       = 3'd7;
                  writeIR = 1'b1;
                  incPC   = 1'b1;
               end
            end
            4'd2: begin
               if (R) begin
                  incPC    = 1'b1;
                  resetIEN = 1'b1;
                  resetR   = 1'b1;
                  sc_d     = 4'd0;
               end else begin
                  S       = 3'd5;
                  writeAR = 1'b1;
                  i_d     = IR[15];
               end
            end
            4'd3: begin
               if (d7) begin
                  sc_d = 4'd0;
                  if (!i_q) begin
                     if (IR[11]) begin
                        resetAC = 1'b1;
                     end else if (IR[10]) begin
                        alu_SEL = ALU_CMA;
                        writeAC = 1'b1;
                     end else if (IR[9] || IR[8]) begin
                        run_d = run_q;
                     end else if (IR[7]) begin
                        alu_SEL = ALU_CIR;
                        writeAC = 1'b1;
                     end else if (IR[6]) begin
                        alu_SEL = ALU_CIL;
                        writeAC = 1'b1;
                     end else if (IR[5]) begin
                        incAC = 1'b1;
                     end else if (IR[4]) begin
                        incPC = ~AC[15];
                     end else if (IR[3]) begin
                        incPC = AC[15];
                     end else if (IR[2]) begin
                        incPC = (AC == 16'd0);
                     end else if (IR[1]) begin
                        run_d = run_q;
                     end else if (IR[0]) begin
                        run_d = 1'b0;
                     end
                  end else if (IR[7]) begin
                     writeIEN = 1'b1;
                  end else if (IR[6]) begin
                     resetIEN = 1'b1;
                  end
               end else if (i_q) begin
                  readMEM = 1'b1;
                  S       = 3'd7;
                  writeAR = 1'b1;
               end
            end
            4'd4: begin
               case (opcode)
                  3'd0, 3'd1, 3'd2, 3'd6: begin
                     readMEM = 1'b1;
                     S       = 3'd7;
                     writeDR = 1'b1;
                  end
                  3'd3: begin
                     S        = 3'd4;
                     writeMEM = 1'b1;
                     sc_d     = 4'd0;
                  end
                  3'd4: begin
                     S       = 3'd1;
                     writePC = 1'b1;
                     sc_d    = 4'd0;
                  end
                  3'd5: begin
                     S        = 3'd2;
                     writeMEM = 1'b1;
                     incAR    = 1'b1;
                  end
                  default: sc_d = 4'd0;
               endcase
            end
            4'd5: begin
               case (opcode)
                  3'd0, 3'd1, 3'd2: begin
                     alu_SEL = (opcode == 3'd0) ? ALU_AND :
                               (opcode == 3'd1) ? ALU_ADD : ALU_LOAD;
                     writeAC = 1'b1;
                     sc_d    = 4'd0;
                  end
                  3'd5: begin
                     S       = 3'd1;
                     writePC = 1'b1;
                     sc_d    = 4'd0;
                  end
                  3'd6: begin
                     incDR = 1'b1;
                  end
                  default: sc_d = 4'd0;
               endcase
            end
            4'd6: begin
               sc_d = 4'd0;
               if (opcode == 3'd6) begin
                  S        = 3'd3;
                  writeMEM = 1'b1;
                  incPC    = (DR == 16'd0);
               end
            end
            default: begin
               sc_d = 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_basic_control_unit.sv
// Self-checking bench for basic_control_unit. The bench plays the datapath:
// it presents IR/AC/DR and keeps its own R and IEN flags, which follow the
// strobes it expects. Expected micro-operations come from instruction-level
// plans built from the machine's behaviour tables.
module tb_basic_control_unit;

   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_LOAD = 3'd2;
   localparam logic [2:0] ALU_CMA  = 3'd3;
   localparam logic [2:0] ALU_CIR  = 3'd4;
   localparam logic [2:0] ALU_CIL  = 3'd5;

   typedef struct packed {
      logic [2:0] s;
      logic [2:0] alu;
      logic rdM, wrM;
      logic rAR, wAR, iAR, rPC, wPC, iPC, rDR, wDR, iDR;
      logic rAC, wAC, iAC, rIR, wIR, iIR, rTR, wTR, iTR;
      logic rIEN, wIEN, rR, wR;
      logic [3:0] sc;
      logic halted;
   } outs_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        irq_req = 1'b0;
   logic [15:0] IR = '0;
   logic [15:0] AC = '0;
   logic [15:0] DR = '0;
   logic        IEN = 1'b0;
   logic        R = 1'b0;
   logic [2:0]  S, alu_SEL;
   logic        readMEM, writeMEM;
   logic        resetAR, writeAR, incAR, resetPC, writePC, incPC, resetDR, writeDR, incDR;
   logic        resetAC, writeAC, incAC, resetIR, writeIR, incIR, resetTR, writeTR, incTR;
   logic        resetIEN, writeIEN, resetR, writeR;
   logic [3:0]  SC;
   logic        halted;
   outs_t       gotV;

   int testCount = 0;
   int failCount = 0;
   logic mR = 1'b0;
   logic mIEN = 1'b0;

   basic_control_unit dut (
      .clk(clk), .reset_n(reset_n), .start(start), .irq_req(irq_req),
      .IR(IR), .AC(AC), .DR(DR), .IEN(IEN), .R(R),
      .S(S), .alu_SEL(alu_SEL), .readMEM(readMEM), .writeMEM(writeMEM),
      .resetAR(resetAR), .writeAR(writeAR), .incAR(incAR),
      .resetPC(resetPC), .writePC(writePC), .incPC(incPC),
      .resetDR(resetDR), .writeDR(writeDR), .incDR(incDR),
      .resetAC(resetAC), .writeAC(writeAC), .incAC(incAC),
      .resetIR(resetIR), .writeIR(writeIR), .incIR(incIR),
      .resetTR(resetTR), .writeTR(writeTR), .incTR(incTR),
      .resetIEN(resetIEN), .writeIEN(writeIEN), .resetR(resetR), .writeR(writeR),
      .SC(SC), .halted(halted)
   );

   // Gather every DUT output into one record so a cycle is checked in one go.
   assign gotV = {S, alu_SEL, readMEM, writeMEM,
                  resetAR, writeAR, incAR, resetPC, writePC, incPC, resetDR, writeDR, incDR,
                  resetAC, writeAC, incAC, resetIR, writeIR, incIR, resetTR, writeTR, incTR,
                  resetIEN, writeIEN, resetR, writeR, SC, halted};

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // An empty cycle record with only the timing state filled in.
   function automatic outs_t blank(input int sc);
      outs_t e;
      e = '0;
      e.sc = sc[3:0];
      return e;
   endfunction

   // What the outputs look like while the init cycle is pending.
   function automatic outs_t initVector();
      outs_t e;
      e = blank(0);
      e.rAR = 1'b1; e.rPC = 1'b1; e.rDR = 1'b1; e.rAC = 1'b1;
      e.rIR = 1'b1; e.rTR = 1'b1; e.rIEN = 1'b1; e.rR = 1'b1;
      return e;
   endfunction

   // Compare one cycle of outputs against the expected record.
   task automatic checkOutput(input string tag, input outs_t got, input outs_t exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, then settle.
   task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] ac,
                                input logic [15:0] dr, input logic irq, input logic startIn);
      @(negedge clk);
      IR = ir;
      AC = ac;
      DR = dr;
      R = mR;
      IEN = mIEN;
      irq_req = irq;
      start = startIn;
      #1;
   endtask

   // Pulse reset for two cycles and check the init cycle that follows.
   task automatic doReset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      start = 1'b0;
      irq_req = 1'b0;
      #1;
      checkOutput({tag, " reset low"}, gotV, initVector());
      @(negedge clk);
      #1;
      checkOutput({tag, " reset held"}, gotV, initVector());
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput({tag, " init cycle"}, gotV, initVector());
      mR = 1'b0;
      mIEN = 1'b0;
   endtask

   // Build the expected cycle plan for one instruction (plus a pending
   // interrupt cycle), then step through it while modelling R and IEN.
   task automatic runInstruction(input string name, input logic [15:0] ir,
                                 input logic [15:0] ac, input logic [15:0] drT6,
                                 input int irqStep, input int irqPct,
                                 input int haltLen, input int abortAt);
      outs_t plan[$];
      outs_t e;
      logic iFlag;
      logic [2:0] op;
      int hb;
      bit halts;
      logic irq;
      logic [15:0] dr;
      halts = 0;
      iFlag = ir[15];
      op = ir[14:12];
      if (mR) begin
         e = blank(0); e.rAR = 1; e.s = 3'd2; e.wTR = 1; plan.push_back(e);
         e = blank(1); e.s = 3'd6; e.wrM = 1; e.rPC = 1; plan.push_back(e);
         e = blank(2); e.iPC = 1; e.rIEN = 1; e.rR = 1; plan.push_back(e);
      end
      e = blank(0); e.s = 3'd2; e.wAR = 1; plan.push_back(e);
      e = blank(1); e.rdM = 1; e.s = 3'd7; e.wIR = 1; e.iPC = 1; plan.push_back(e);
      e = blank(2); e.s = 3'd5; e.wAR = 1; plan.push_back(e);
      e = blank(3);
      if (op == 3'd7 && !iFlag) begin
         hb = -1;
         for (int b = 11; b >= 0; b--) begin
            if (ir[b]) begin
               hb = b;
               break;
            end
         end
         case (hb)
            11: e.rAC = 1;
            10: begin e.alu = ALU_CMA; e.wAC = 1; end
            7:  begin e.alu = ALU_CIR; e.wAC = 1; end
            6:  begin e.alu = ALU_CIL; e.wAC = 1; end
            5:  e.iAC = 1;
            4:  e.iPC = (ac[15] == 1'b0);
            3:  e.iPC = (ac[15] == 1'b1);
            2:  e.iPC = (ac == 16'd0);
            0:  halts = 1;
            default: ;
         endcase
         plan.push_back(e);
      end else if (op == 3'd7) begin
         if (ir[7]) e.wIEN = 1;
         else if (ir[6]) e.rIEN = 1;
         plan.push_back(e);
      end else begin
         if (iFlag) begin e.rdM = 1; e.s = 3'd7; e.wAR = 1; end
         plan.push_back(e);
         case (op)
            3'd0, 3'd1, 3'd2: begin
               e = blank(4); e.rdM = 1; e.s = 3'd7; e.wDR = 1; plan.push_back(e);
               e = blank(5); e.wAC = 1;
               e.alu = (op == 3'd0) ? ALU_AND : (op == 3'd1) ? ALU_ADD : ALU_LOAD;
               plan.push_back(e);
            end
            3'd3: begin e = blank(4); e.s = 3'd4; e.wrM = 1; plan.push_back(e); end
            3'd4: begin e = blank(4); e.s = 3'd1; e.wPC = 1; plan.push_back(e); end
            3'd5: begin
               e = blank(4); e.s = 3'd2; e.wrM = 1; e.iAR = 1; plan.push_back(e);
               e = blank(5); e.s = 3'd1; e.wPC = 1; plan.push_back(e);
            end
            default: begin
               e = blank(4); e.rdM = 1; e.s = 3'd7; e.wDR = 1; plan.push_back(e);
               e = blank(5); e.iDR = 1; plan.push_back(e);
               e = blank(6); e.s = 3'd3; e.wrM = 1; e.iPC = (drT6 == 16'd0); plan.push_back(e);
            end
         endcase
      end
      for (int k = 0; k < plan.size(); k++) begin
         if (abortAt >= 0 && k == abortAt) return;
         irq = (k == irqStep) || ($urandom_range(0, 99) < irqPct);
         dr = (plan[k].sc == 4'd6) ? drT6 : 16'($urandom);
         applyStimulus(ir, ac, dr, irq, $urandom_range(0, 15) == 0);
         e = plan[k];
         if (e.sc >= 4'd3 && e.sc <= 4'd6 && !mR && mIEN && irq) e.wR = 1;
         checkOutput($sformatf("%s T%0d", name, e.sc), gotV, e);
         if (e.wR) mR = 1'b1;
         if (e.rR) mR = 1'b0;
         if (e.wIEN) mIEN = 1'b1;
         if (e.rIEN) mIEN = 1'b0;
      end
      if (halts) begin
         e = blank(0);
         e.halted = 1'b1;
         for (int k = 0; k < haltLen; k++) begin
            applyStimulus(ir, ac, 16'($urandom), $urandom_range(0, 3) == 0, 1'b0);
            checkOutput($sformatf("%s halted", name), gotV, e);
         end
         applyStimulus(ir, ac, 16'($urandom), 1'b0, 1'b1);
         checkOutput($sformatf("%s start", name), gotV, e);
      end
   endtask

   // Directed scenarios first, then a randomized instruction stream.
   initial begin
      logic [15:0] ir, ac, drT6;
      logic [15:0] ioList [4];
      int kind, b;
      ioList[0] = 16'hF080; ioList[1] = 16'hF040; ioList[2] = 16'hF200; ioList[3] = 16'hF000;

      doReset("power-on");
      runInstruction("ADD", 16'h1020, 16'd5, 16'd7, -1, 0, 0, -1);
      runInstruction("LDA ind", 16'hA030, 16'h1234, 16'd0, -1, 0, 0, -1);
      runInstruction("ISZ zero", 16'h6040, 16'h0, 16'h0000, -1, 0, 0, -1);
      runInstruction("ISZ one", 16'h6040, 16'h0, 16'h0001, -1, 0, 0, -1);
      mIEN = 1'b1;
      runInstruction("ADD irq", 16'h1020, 16'd5, 16'd7, 4, 0, 0, -1);
      runInstruction("after irq", 16'h2010, 16'd0, 16'd0, -1, 0, 0, -1);
      runInstruction("HLT", 16'h7001, 16'd0, 16'd0, -1, 0, 10, -1);
      runInstruction("ION", 16'hF080, 16'd0, 16'd0, -1, 0, 0, -1);
      runInstruction("IOF", 16'hF040, 16'd0, 16'd0, -1, 0, 0, -1);
      runInstruction("SZA", 16'h7004, 16'd0, 16'd0, -1, 0, 0, -1);
      runInstruction("SPA", 16'h7010, 16'h8000, 16'd0, -1, 0, 0, -1);

      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 9) mIEN = 1'b1;
         if (kind <= 5 || kind == 9) begin
            ir = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), 12'($urandom)};
         end else if (kind <= 7) begin
            b = $urandom_range(0, 12);
            if (b == 12) ir = 16'h7000;
            else ir = 16'h7000 | (16'd1 << b) | (16'($urandom) & ((16'd1 << b) - 16'd1));
         end else begin
            ir = ioList[$urandom_range(0, 3)];
         end
         case ($urandom_range(0, 2))
            0: ac = 16'd0;
            1: ac = 16'h8000 | 16'($urandom);
            default: ac = 16'h7FFF & 16'($urandom);
         endcase
         drT6 = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(1, 65535));
         runInstruction($sformatf("rnd%0d", n), ir, ac, drT6, -1, 10, $urandom_range(2, 6), -1);
      end

      runInstruction("ADD abort", 16'h1020, 16'd5, 16'd7, -1, 0, 0, 5);
      doReset("mid-instr");
      runInstruction("post-reset", 16'h4123, 16'd0, 16'd0, -1, 0, 0, -1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
